// File: rtl/bm_dl_bit_serial_subtractor.sv
// rtl/bm_dl_bit_serial_subtractor.sv - bit-serial subtractor, one full-subtractor cell, LSB first
//
// Computes D = X - Y - borrowin (mod 2**WIDTH) over WIDTH SHIFT cycles.
// Optional feature macro: BM_DL_SUB_OVERFLOW_EN (adds the overflow output).
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request, sampled only in IDLE
//   borrowin   borrow into bit 0, captured with X/Y
//   X, Y       minuend / subtrahend, captured when start is accepted
//   busy       high while in SHIFT
//   done       one-cycle pulse in DONE
//   D          difference, held until the next result is written
//   borrowout  borrow out of the MSB, held like D
//   overflow   (macro only) two's-complement overflow, held like D
module bm_dl_bit_serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             borrowin,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
`ifdef BM_DL_SUB_OVERFLOW_EN
    output logic             borrowout,
    output logic             overflow
`else
    output logic             borrowout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             b_q, b_d;
    logic             bout_q, bout_d;

    logic diff_bit;
    logic b_next;
    logic last_bit;

`ifdef BM_DL_SUB_OVERFLOW_EN
    logic ovf_q, ovf_d;
`endif

    // Registered full-subtractor cell operating on the current LSBs.
    always_comb begin
        diff_bit = xs_q[0] ^ ys_q[0] ^ b_q;
        b_next   = (~xs_q[0] & ys_q[0]) | (~xs_q[0] & b_q) | (ys_q[0] & b_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            rs_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            b_q     <= 1'b0;
            bout_q  <= 1'b0;
`ifdef BM_DL_SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            rs_q    <= rs_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            bout_q  <= bout_d;
`ifdef BM_DL_SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values. The result registers are written only on the
    // last shift, so the previous answer stays visible throughout SHIFT.
    always_comb begin
        xs_d   = xs_q;
        ys_d   = ys_q;
        rs_d   = rs_q;
        res_d  = res_q;
        cnt_d  = cnt_q;
        b_d    = b_q;
        bout_d = bout_q;
`ifdef BM_DL_SUB_OVERFLOW_EN
        ovf_d  = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xs_d  = X;
                    ys_d  = Y;
                    b_d   = borrowin;
                    cnt_d = '0;
                end
            end
            S_SHIFT: begin
                b_d   = b_next;
                rs_d  = {diff_bit, {(WIDTH-1){1'b0}}} | (rs_q >> 1);
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    res_d  = rs_d;
                    bout_d = b_next;
`ifdef BM_DL_SUB_OVERFLOW_EN
                    // On the last shift xs_q[0]/ys_q[0] are the captured
                    // operand MSBs and diff_bit is the result MSB.
                    ovf_d  = (xs_q[0] != ys_q[0]) && (diff_bit != xs_q[0]);
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        busy      = (state_q == S_SHIFT);
        done      = (state_q == S_DONE);
        D         = res_q;
        borrowout = bout_q;
`ifdef BM_DL_SUB_OVERFLOW_EN
        overflow  = ovf_q;
`endif
    end

endmodule
